div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle RV64M integer divide/remainder unit living in the execute stage. It accepts DIV, DIVU, REM, REMU and their W forms from E, iterates a radix-2 restoring divider, and drives a stall request into the hazard unit. The hazard unit ORs that request into its stall/flush outputs so F, D and E freeze and a bubble enters M until the result is ready. It is the stall producer on the hazard interface: the hazard unit consumes stall reasons, and this block generates one.

## Interface
Parameters:
- XLEN, 64, datapath width; W ops use the low XLEN/2 bits.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; synchronous, active-high.
- startE  in  1  E holds a valid divide-class instruction.
- funct3E  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- wordE  in  1  W variant (DIVW/DIVUW/REMW/REMUW).
- srcaE  in  XLEN  dividend (forwarded rs1 value).
- srcbE  in  XLEN  divisor (forwarded rs2 value).
- killE  in  1  abort the in-flight operation (exception/redirect).
- stallreq  out  1  to hazard unit; freezes F/D/E.
- done  out  1  result valid this cycle.
- result  out  XLEN  quotient or remainder.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - stallreq = startE & ~killE.
  - On start, latch operands and op. Special cases go directly to DONE; all other ops go to BUSY with count = XLEN (or XLEN/2 for W).
- W ops:
  - Operands are the low 32 bits, sign-extended (signed ops) or zero-extended (unsigned ops).
  - The final 32-bit result is sign-extended to XLEN, for both signed and unsigned W ops.
- Signed ops:
  - Divide the magnitudes.
  - Negate the quotient when the operand signs differ.
  - The remainder takes the sign of the dividend.
- Divide by zero (divisor == 0, in the effective width):
  - quotient = all ones.
  - remainder = dividend.
- Signed overflow (most-negative / -1, in the effective width):
  - quotient = dividend.
  - remainder = 0.
- BUSY:
  - Each cycle: shift {rem, quo} left one bit, trial-subtract the divisor from rem, keep the difference if it is non-negative, and set the quotient LSB accordingly.
  - Decrement count; when count reaches 0, go to DONE.
  - stallreq = 1 throughout.
- DONE:
  - done = 1, result valid, stallreq = 0, so the pipeline advances this cycle.
  - Next state is IDLE unconditionally. startE seen in DONE belongs to the finishing instruction and is ignored.
- killE:
  - In any state, next state is IDLE, no done is produced, and stallreq = 0 in the same cycle.
  - killE together with startE: kill wins.
- Reset values:
  - state = IDLE, count = 0, result = 0, done = 0.
  - stallreq is forced to 0 while rst is high.

## Timing
- Start seen in cycle T (IDLE), normal op:
  - stallreq is high in T..T+N, with N = 64 (or 32 for W).
  - done and result appear in T+N+1.
  - Total occupancy of E is N+2 cycles.
- Special case (divide by zero or overflow):
  - stallreq is high in T only.
  - done appears in T+1.
- Back-to-back divides:
  - The second divide reaches E in the cycle after DONE and is seen in IDLE.
  - There is no lost or duplicated start.
- done and result are registered outputs; stallreq is combinational from state, startE and killE.
- Operands are sampled only in IDLE. Forwarding changes during BUSY have no effect.

## Structure
- Shared package:
  - funct3 encodings (DIV_F3, DIVU_F3, REM_F3, REMU_F3).
  - State encoding (IDLE/BUSY/DONE).
  - XLEN constant.
- One sub-module, div_step:
  - Combinational single restoring iteration.
  - Inputs: rem, quo, divisor. Outputs: next rem, next quo.
  - Instantiated once; the FSM, sign fix-up, special cases and W extension stay in div_unit.

## Test plan
- DIV 100 / 7:
  - stallreq high for 65 cycles.
  - done with result 14.
  - REM on the same operands gives 2.
- REM -7 / 2:
  - result 0xFFFF_FFFF_FFFF_FFFF (-1).
  - DIV on the same operands gives 0xFFFF_FFFF_FFFF_FFFD (-3).
- DIVU x / 0:
  - result 0xFFFF_FFFF_FFFF_FFFF, with a 1-cycle stall.
  - REMU 0x1234 / 0 gives 0x1234.
- DIV 0x8000_0000_0000_0000 / -1:
  - result 0x8000_0000_0000_0000, with a 1-cycle stall.
  - REM on the same operands gives 0.
- W ops:
  - DIVW 0x0000_0000_8000_0000 / 0xFFFF_FFFF (32-bit overflow) gives 0xFFFF_FFFF_8000_0000.
  - DIVUW 0xFFFF_FFFF_FFFF_FFFE / 2 gives 0x0000_0000_7FFF_FFFF after a 33-cycle stall.
- killE in BUSY cycle 10:
  - stallreq drops the same cycle and state returns to IDLE.
  - No done pulse.
  - An immediately following DIVU 9 / 3 gives 3 after the normal latency.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared constants for the execute-stage integer divider: funct3 codes,
// FSM state encoding and the default datapath width.
package div_unit_pkg;

    localparam int DU_XLEN = 64;

    typedef enum logic [2:0] {
        DIV_F3  = 3'b100,
        DIVU_F3 = 3'b101,
        REM_F3  = 3'b110,
        REMU_F3 = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_unit_if.sv
// E-stage <-> divider bundle: the operation request from E and the
// stall/result path back toward the hazard unit and M.
interface div_unit_if #(
    parameter int XLEN = 64
);
    logic            startE;
    logic [2:0]      funct3E;
    logic            wordE;
    logic [XLEN-1:0] srcaE;
    logic [XLEN-1:0] srcbE;
    logic            killE;
    logic            stallreq;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output startE, funct3E, wordE, srcaE, srcbE, killE,
        input  stallreq, done, result
    );

    modport slave (
        input  startE, funct3E, wordE, srcaE, srcbE, killE,
        output stallreq, done, result
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract
// the divisor, keep the difference when it does not borrow.
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_borrow;

    // rem < divisor holds between steps, so bit XLEN of the difference is a true borrow
    assign w_shift  = {i_rem, i_quo[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, i_divisor};
    assign w_borrow = w_diff[XLEN];

    assign o_rem = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], ~w_borrow};
endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV64M DIV/DIVU/REM/REMU (+W forms) with a stall request
// toward the hazard unit.
//   state | meaning
//   IDLE  | waiting for a divide in E; special cases resolve straight to DONE
//   BUSY  | one restoring iteration per cycle, E frozen
//   DONE  | result/done valid for one cycle, pipeline advances
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = DU_XLEN
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  du
);
    localparam int HALF  = XLEN / 2;
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [XLEN-1:0]  MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [HALF-1:0]  MIN_HALF = {1'b1, {(HALF-1){1'b0}}};

    state_e            r_state, w_next_state;
    logic [CNT_W-1:0]  r_count;
    logic [XLEN-1:0]   r_rem, r_quo, r_divisor, r_result;
    logic              r_neg_q, r_neg_r, r_is_rem, r_word, r_done;

    logic              w_signed, w_is_rem, w_start, w_special, w_stallreq;
    logic              w_a_neg, w_b_neg, w_a_min, w_div_zero, w_ovf;
    logic [XLEN-1:0]   w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_quo_init;
    logic [XLEN-1:0]   w_spec_raw, w_step_rem, w_step_quo, w_q_fix, w_r_fix;

    function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] v, input logic w);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    always_comb begin
        w_signed = 1'b0;
        w_is_rem = 1'b0;
        case (du.funct3E)
            DIV_F3:  w_signed = 1'b1;
            REM_F3:  begin w_signed = 1'b1; w_is_rem = 1'b1; end
            REMU_F3: w_is_rem = 1'b1;
            default: ;
        endcase
    end

    // Operand conditioning: W extension, magnitudes, special-case detection
    always_comb begin
        w_a_ext = du.srcaE;
        w_b_ext = du.srcbE;
        w_a_min = (du.srcaE == MIN_FULL);
        if (du.wordE) begin
            w_a_ext = {{HALF{w_signed & du.srcaE[HALF-1]}}, du.srcaE[HALF-1:0]};
            w_b_ext = {{HALF{w_signed & du.srcbE[HALF-1]}}, du.srcbE[HALF-1:0]};
            w_a_min = (du.srcaE[HALF-1:0] == MIN_HALF);
        end
        w_a_neg    = w_signed & w_a_ext[XLEN-1];
        w_b_neg    = w_signed & w_b_ext[XLEN-1];
        w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
        w_quo_init = du.wordE ? (w_a_mag << HALF) : w_a_mag;
        w_div_zero = (w_b_ext == '0);
        w_ovf      = w_signed & w_a_min & (w_b_ext == '1);
        w_special  = w_div_zero | w_ovf;
        if (w_div_zero)
            w_spec_raw = w_is_rem ? w_a_ext : '1;
        else
            w_spec_raw = w_is_rem ? '0 : w_a_ext;
    end

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    assign w_q_fix = r_neg_q ? -w_step_quo : w_step_quo;
    assign w_r_fix = r_neg_r ? -w_step_rem : w_step_rem;
    assign w_start = du.startE & ~du.killE;

    always_comb begin
        w_next_state = r_state;
        w_stallreq   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_stallreq   = 1'b1;
                    w_next_state = w_special ? DONE : BUSY;
                end
            end
            BUSY: begin
                w_stallreq = 1'b1;
                if (r_count == CNT_W'(1))
                    w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (du.killE) begin
            w_next_state = IDLE;
            w_stallreq   = 1'b0;
        end
        if (rst)
            w_stallreq = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
            r_word    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_next_state == DONE);
            if (du.killE) begin
                r_count <= '0;
            end else if (r_state == IDLE && w_start) begin
                r_rem     <= '0;
                r_quo     <= w_quo_init;
                r_divisor <= w_b_mag;
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
                r_is_rem  <= w_is_rem;
                r_word    <= du.wordE;
                r_count   <= w_special ? '0 : (du.wordE ? CNT_HALF : CNT_FULL);
                if (w_special)
                    r_result <= word_fix(w_spec_raw, du.wordE);
            end else if (r_state == BUSY) begin
                r_rem   <= w_step_rem;
                r_quo   <= w_step_quo;
                r_count <= r_count - CNT_W'(1);
                if (r_count == CNT_W'(1))
                    r_result <= word_fix(r_is_rem ? w_r_fix : w_q_fix, r_word);
            end
        end
    end

    assign du.stallreq = w_stallreq;
    assign du.done     = r_done;
    assign du.result   = r_result;
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, stall length, special cases,
// W forms, kill behaviour and back-to-back issue.
module tb_div_unit;
    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    div_unit_if #(.XLEN(64)) du_if ();

    div_unit #(.XLEN(64)) u_dut (
        .clk (clk),
        .rst (rst),
        .du  (du_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Issue one op at a negedge, hold it in E until done, scramble operands while stalled
    task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_stall);
        int          stalls;
        logic        got;
        logic [63:0] res;
        du_if.startE  = 1'b1;
        du_if.funct3E = f3;
        du_if.wordE   = w;
        du_if.srcaE   = a;
        du_if.srcbE   = b;
        du_if.killE   = 1'b0;
        stalls = 0;
        got    = 1'b0;
        res    = '0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (du_if.done) begin
                got = 1'b1;
                res = du_if.result;
                break;
            end
            if (du_if.stallreq) stalls++;
            @(negedge clk);
            du_if.srcaE = {$urandom, $urandom};
            du_if.srcbE = {$urandom, $urandom};
        end
        chk({tag, " done"}, {63'd0, got}, 64'd1);
        chk({tag, " result"}, res, exp_res);
        chk({tag, " stall"}, 64'(stalls), 64'(exp_stall));
        @(negedge clk);
        du_if.startE = 1'b0;
    endtask

    initial begin
        logic seen_done;
        du_if.startE  = 1'b1;
        du_if.funct3E = F_DIV;
        du_if.wordE   = 1'b0;
        du_if.srcaE   = 64'd100;
        du_if.srcbE   = 64'd7;
        du_if.killE   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst stallreq", {63'd0, du_if.stallreq}, 64'd0);
        du_if.startE = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst done", {63'd0, du_if.done}, 64'd0);
        chk("rst result", du_if.result, 64'd0);
        @(negedge clk);

        run_op("div 100/7",  F_DIV,  1'b0, 64'd100, 64'd7, 64'd14, 65);
        run_op("rem 100/7",  F_REM,  1'b0, 64'd100, 64'd7, 64'd2, 65);
        run_op("rem -7/2",   F_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("div -7/2",   F_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("div 7/-2",   F_DIV,  1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem 7/-2",   F_REM,  1'b0, 64'd7, -64'sd2, 64'd1, 65);
        run_op("divu big",   F_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 65);
        run_op("divu x/0",   F_DIVU, 1'b0, 64'hDEAD, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu x/0",   F_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
        run_op("div ovf",    F_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1);
        run_op("rem ovf",    F_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("divw ovf",   F_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1);
        run_op("divuw",      F_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
        run_op("divuw sext", F_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("remw -7/2",  F_REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'hAAAA_0000_0000_0002,
               64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("remuw x/0",  F_REMU, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
               64'hFFFF_FFFF_8000_0001, 1);

        // Kill in the tenth BUSY cycle
        du_if.startE  = 1'b1;
        du_if.funct3E = F_DIVU;
        du_if.wordE   = 1'b0;
        du_if.srcaE   = 64'd1000;
        du_if.srcbE   = 64'd3;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (du_if.done) seen_done = 1'b1;
            @(negedge clk);
        end
        du_if.killE = 1'b1;
        #1;
        chk("kill stallreq", {63'd0, du_if.stallreq}, 64'd0);
        @(negedge clk);
        du_if.killE  = 1'b0;
        du_if.startE = 1'b0;
        #1;
        if (du_if.done) seen_done = 1'b1;
        chk("kill no done", {63'd0, seen_done}, 64'd0);
        chk("kill idle stall", {63'd0, du_if.stallreq}, 64'd0);
        @(negedge clk);
        run_op("divu after kill", F_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 65);

        // Kill together with start in IDLE
        du_if.startE = 1'b1;
        du_if.killE  = 1'b1;
        #1;
        chk("kill+start stall", {63'd0, du_if.stallreq}, 64'd0);
        @(negedge clk);
        du_if.startE = 1'b0;
        du_if.killE  = 1'b0;
        #1;
        chk("kill+start done", {63'd0, du_if.done}, 64'd0);
        chk("kill+start idle", {63'd0, du_if.stallreq}, 64'd0);
        @(negedge clk);
        run_op("remu after kill", F_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
